axis_insert_header_pipe: RTL

- Parametrised successor header inserter for AXI-Stream packets.
- Accepts one header per packet: 0..DATA_BYTE_WD valid bytes. Prepends it to the following payload packet and re-packs the byte stream into full-width output beats.
- Full ready/valid backpressure on all three interfaces, a registered output stage, and an automatic extra flush beat when the residual bytes overflow.
- Sits between the packet source and the downstream AXI-Stream sink.

---
 rtl/axis_insert_header_pipe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/axis_insert_header_pipe.sv
// AXI-Stream header inserter: prepends a 0..N byte header to each payload packet
// and re-packs the byte stream into full-width beats behind a registered output stage.
module axis_insert_header_pipe #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,

    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,

    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
    output logic                    ready_insert,
    output logic                    hdr_err
);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    localparam logic [BYTE_CNT_WD-1:0] N_B   = BYTE_CNT_WD'(DATA_BYTE_WD);
    localparam logic [BYTE_CNT_WD:0]   N_CNT = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);

    state_t                   state;
    logic [BYTE_CNT_WD-1:0]   h_q;
    logic [BYTE_CNT_WD-1:0]   rem_q;
    logic [DATA_WD-1:0]       carry_q;

    function automatic logic [DATA_BYTE_WD-1:0] msb_ones(input logic [BYTE_CNT_WD:0] n);
        logic [DATA_BYTE_WD-1:0] r;
        for (int i = 0; i < DATA_BYTE_WD; i++) r[DATA_BYTE_WD-1-i] = (i < int'(n));
        return r;
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] lsb_ones(input logic [BYTE_CNT_WD:0] n);
        logic [DATA_BYTE_WD-1:0] r;
        for (int i = 0; i < DATA_BYTE_WD; i++) r[i] = (i < int'(n));
        return r;
    endfunction

    function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] r;
        for (int i = 0; i < DATA_BYTE_WD; i++) r[8*i +: 8] = {8{k[i]}};
        return r;
    endfunction

    logic                    hdr_fire, in_fire, out_free, hdr_over, overflow;
    logic [BYTE_CNT_WD-1:0]  hdr_h, in_cnt, rem;
    logic [BYTE_CNT_WD:0]    total;
    logic [DATA_WD-1:0]      hdr_carry, in_data, beat_data, next_carry;

    assign out_free     = !valid_out || ready_out;
    assign ready_in     = (state == STREAM) && out_free;
    // The next header waits until the previous packet's last beat has left the output register.
    assign ready_insert = (state == IDLE) && !valid_out;
    assign hdr_fire     = valid_insert && ready_insert;
    assign in_fire      = valid_in && ready_in;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        in_cnt = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) in_cnt = in_cnt + BYTE_CNT_WD'(keep_in[i]);
    end

    assign hdr_over   = {1'b0, byte_insert_cnt} > N_CNT;
    assign hdr_h      = hdr_over ? N_B : byte_insert_cnt;
    assign hdr_err    = hdr_fire && (hdr_over || keep_insert != lsb_ones({1'b0, byte_insert_cnt}));
    assign hdr_carry  = (data_insert & byte_mask(lsb_ones({1'b0, hdr_h}))) << {N_B - hdr_h, 3'b000};

    // Invalid payload bytes are masked so they never reach data_out.
    assign in_data    = data_in & byte_mask(keep_in);
    assign beat_data  = carry_q | (in_data >> {h_q, 3'b000});
    assign next_carry = in_data << {N_B - h_q, 3'b000};
    assign total      = {1'b0, h_q} + {1'b0, in_cnt};
    assign overflow   = total > N_CNT;
    assign rem        = BYTE_CNT_WD'(total - N_CNT);

    // NOTE: reset is synchronous and clears the output stage and the carry/count registers
    // too, so a packet cut short by reset leaves nothing behind; all state uses <=.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            h_q       <= '0;
            rem_q     <= '0;
            carry_q   <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else begin
            if (valid_out && ready_out) valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (hdr_fire) begin
                        h_q     <= hdr_h;
                        carry_q <= hdr_carry;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (in_fire) begin
                        valid_out <= 1'b1;
                        data_out  <= beat_data;
                        carry_q   <= next_carry;
                        if (last_in && !overflow) begin
                            keep_out <= msb_ones(total);
                            last_out <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            keep_out <= '1;
                            last_out <= 1'b0;
                            if (last_in) begin
                                rem_q <= rem;
                                state <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        valid_out <= 1'b1;
                        data_out  <= carry_q;
                        keep_out  <= msb_ones({1'b0, rem_q});
                        last_out  <= 1'b1;
                        carry_q   <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
